// File: rtl/universal_shift_register.sv
// Universal WIDTH-bit shift register (hold / shift left / shift right / load) with a shift counter and word-done pulse.
// Latency: one clock from inputs to q, shift_count and word_done; serial outputs follow q combinationally.
// Backpressure: none; enable=0 freezes all state. Optional rotate input exists only when USR_ROTATE_EN is defined.
module universal_shift_register #(
    parameter  int               WIDTH       = 8,
    parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int               CW          = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic [CW-1:0]    shift_count,
    output logic             word_done
`ifdef USR_ROTATE_EN
    ,
    input  logic             rotate
`endif
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    // Bits entering the vacated end on a shift; rotation feeds back the outgoing bit.
    logic fill_lsb;
    logic fill_msb;

    // Select the fill bit for each shift direction.
    always_comb begin
        fill_lsb = serial_in_right;
        fill_msb = serial_in_left;
`ifdef USR_ROTATE_EN
        if (rotate) begin
            fill_lsb = q[WIDTH-1];
            fill_msb = q[0];
        end
`endif
    end

    // Register bank, shift counter and word-done pulse; reset discards any partial word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q           <= RESET_VALUE;
            shift_count <= '0;
            word_done   <= 1'b0;
        end else begin
            // word_done is a single-cycle pulse: cleared unless this edge completes a word.
            word_done <= 1'b0;
            if (enable) begin
                case (mode)
                    MODE_HOLD: begin
                        q <= q;
                    end
                    MODE_LEFT: begin
                        q <= {q[WIDTH-2:0], fill_lsb};
                        if (shift_count != COUNT_FULL) begin
                            shift_count <= shift_count + CW'(1);
                        end
                        word_done <= (shift_count == COUNT_LAST);
                    end
                    MODE_RIGHT: begin
                        q <= {fill_msb, q[WIDTH-1:1]};
                        if (shift_count != COUNT_FULL) begin
                            shift_count <= shift_count + CW'(1);
                        end
                        word_done <= (shift_count == COUNT_LAST);
                    end
                    MODE_LOAD: begin
                        q           <= parallel_in;
                        shift_count <= '0;
                    end
                    default: begin
                        q <= q;
                    end
                endcase
            end
        end
    end

    assign serial_out_left  = q[WIDTH-1];
    assign serial_out_right = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): directed scenarios plus random traffic.
// Expected state comes from an arithmetic reference model pushed into a scoreboard queue.
// A monitor pops one expectation after every clock edge that had stimulus issued for it.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          serial_in_left = 1'b0;
    logic          serial_in_right = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic [W-1:0]  q;
    logic          serial_out_left;
    logic          serial_out_right;
    logic [CW-1:0] shift_count;
    logic          word_done;
`ifdef USR_ROTATE_EN
    logic          rotate = 1'b0;
`endif

    universal_shift_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .mode             (mode),
        .serial_in_left   (serial_in_left),
        .serial_in_right  (serial_in_right),
        .parallel_in      (parallel_in),
        .q                (q),
        .serial_out_left  (serial_out_left),
        .serial_out_right (serial_out_right),
        .shift_count      (shift_count),
        .word_done        (word_done)
`ifdef USR_ROTATE_EN
        ,
        .rotate           (rotate)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        longint q;
        int     cnt;
        int     wd;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model state: register value as an integer, shift count as a plain int.
    longint mq = 0;
    int     mc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock's worth of the behavioural rules and queue the result.
    task automatic model(input bit en, input bit [1:0] md, input bit l, input bit r,
                         input longint p, input bit rot);
        exp_t   e;
        longint full = longint'(1) << W;
        longint half = full / 2;
        longint fill;
        int     wd = 0;
        if (en) begin
            if (md == 2'd1) begin
                fill = rot ? (mq / half) : longint'(r);
                mq   = (mq * 2) % full + fill;
                if (mc == W - 1) wd = 1;
                if (mc < W) mc++;
            end else if (md == 2'd2) begin
                fill = rot ? (mq % 2) : longint'(l);
                mq   = mq / 2 + fill * half;
                if (mc == W - 1) wd = 1;
                if (mc < W) mc++;
            end else if (md == 2'd3) begin
                mq = p;
                mc = 0;
            end
        end
        e.q = mq; e.cnt = mc; e.wd = wd;
        sb.push_back(e);
    endtask

    // Drive inputs now (caller is at a falling edge) and record the expectation.
    task automatic drive(input bit en, input bit [1:0] md, input bit l, input bit r,
                         input logic [W-1:0] p, input bit rot = 1'b0);
        bit rot_eff = 1'b0;
        enable          = en;
        mode            = md;
        serial_in_left  = l;
        serial_in_right = r;
        parallel_in     = p;
`ifdef USR_ROTATE_EN
        rotate  = rot;
        rot_eff = rot;
`endif
        model(en, md, l, r, longint'(p), rot_eff);
    endtask

    task automatic step(input bit en, input bit [1:0] md, input bit l, input bit r,
                        input logic [W-1:0] p, input bit rot = 1'b0);
        @(negedge clock);
        drive(en, md, l, r, p, rot);
    endtask

    // Pull reset between edges, check the immediate clear, hold it across one edge, release.
    task automatic do_reset();
        exp_t e;
        @(negedge clock);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_q", longint'(q), 0);
        chk("async_rst_cnt", longint'(shift_count), 0);
        chk("async_rst_wd", longint'(word_done), 0);
        mq = 0;
        mc = 0;
        e.q = 0; e.cnt = 0; e.wd = 0;
        sb.push_back(e);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: after each edge that has a queued expectation, compare every output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", longint'(q), e.q);
                chk("serial_out_left", longint'(serial_out_left), (e.q >> (W - 1)) & 1);
                chk("serial_out_right", longint'(serial_out_right), e.q & 1);
                chk("shift_count", longint'(shift_count), longint'(e.cnt));
                chk("word_done", longint'(word_done), longint'(e.wd));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] seq;
        logic [7:0] bits;

        // Power-on reset state.
        #3;
        chk("por_q", longint'(q), 0);
        chk("por_cnt", longint'(shift_count), 0);
        chk("por_wd", longint'(word_done), 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: load A5, then async clear between edges.
        step(1, 2'b11, 0, 0, 8'hA5);
        do_reset();

        // 2: load 3C and hold for five edges.
        step(1, 2'b11, 0, 0, 8'h3C);
        repeat (5) step(1, 2'b00, 1, 1, 8'hFF);
        @(negedge clock);
        chk("t2_hold_q", longint'(q), 64'h3C);
        drive(1, 2'b11, 0, 0, 8'h81);

        // 3: shift 81 out to the left, serial_out_left sampled before each edge.
        seq = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t3_sol_seq", longint'(serial_out_left), longint'(seq[7-i]));
            if (i < 7) chk("t3_wd_early", longint'(word_done), 0);
            drive(1, 2'b01, 1, 0, 8'h00);
        end
        @(negedge clock);
        chk("t3_final_q", longint'(q), 0);
        chk("t3_wd_8th", longint'(word_done), 1);
        chk("t3_cnt_8th", longint'(shift_count), 8);
        drive(1, 2'b01, 0, 0, 8'h00);
        @(negedge clock);
        chk("t3_cnt_sat", longint'(shift_count), 8);
        chk("t3_wd_sat", longint'(word_done), 0);
        drive(1, 2'b00, 0, 0, 8'h00);

        // 4: from reset, deserialise 1,0,1,1,0,0,1,0 through the MSB.
        do_reset();
        bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) step(1, 2'b10, bits[7-i], 1, 8'hFF);
        @(negedge clock);
        chk("t4_q", longint'(q), 64'h4D);
        chk("t4_wd", longint'(word_done), 1);
        drive(1, 2'b00, 0, 0, 8'h00);
        @(negedge clock);
        chk("t4_wd_once", longint'(word_done), 0);

        // 5: enable low blocks shifting.
        drive(1, 2'b11, 0, 0, 8'hF0);
        repeat (4) step(0, 2'b01, 1, 1, 8'h00);
        @(negedge clock);
        chk("t5_q", longint'(q), 64'hF0);
        chk("t5_cnt", longint'(shift_count), 0);
        chk("t5_wd", longint'(word_done), 0);
        drive(1, 2'b00, 0, 0, 8'h00);

`ifdef USR_ROTATE_EN
        // 6: rotate right through a full word.
        step(1, 2'b11, 0, 0, 8'h81);
        step(1, 2'b10, 0, 0, 8'h00, 1'b1);
        @(negedge clock);
        chk("t6_q_first", longint'(q), 64'hC0);
        drive(1, 2'b10, 0, 0, 8'h00, 1'b1);
        repeat (6) step(1, 2'b10, 0, 0, 8'h00, 1'b1);
        @(negedge clock);
        chk("t6_q_final", longint'(q), 64'h81);
        chk("t6_wd", longint'(word_done), 1);
        drive(1, 2'b00, 0, 0, 8'h00);
`endif

        // Random traffic with occasional mid-sequence resets; loads kept rare so counts saturate.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                bit [1:0] md;
                int       r = $urandom_range(0, 19);
                md = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : (r < 12) ? 2'b01 : 2'b10;
                step($urandom_range(0, 7) != 0, md, 1'($urandom), 1'($urandom),
                     W'($urandom), 1'($urandom));
            end
        end

        // Drain the scoreboard with a bounded wait.
        step(0, 2'b00, 0, 0, 8'h00);
        repeat (4) @(posedge clock);
        #2;
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
